count_ctrl: RTL and testbench
=============================

# count_ctrl

User-control front end for the 4-digit seconds counter display. Takes two raw push-buttons (mode, run) and produces clean control levels for the display counter: `hex` (hex/decimal display select, wired straight to the counter's `hex` input), `run` (count enable) and a one-cycle `clear` pulse. Each button is synchronised and debounced. The run button tells a short press (toggle run) from a long press (clear) with a small FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 32'd500000: consecutive stable cycles required to accept a new button level; must be ≥1.
- `LONG_CYCLES`, default 32'd50000000: debounced hold time on the run button that counts as a long press; must be ≥2.
- `RUN_INIT`, default 1'b1: value of `run` out of reset.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `btn_mode` input 1: raw mode button, active-high, asynchronous to `clk`.
- `btn_run` input 1: raw run button, active-high, asynchronous to `clk`.
- `hex` output 1: 1 = hex display, 0 = decimal; toggles once per debounced mode press.
- `run` output 1: counter enable level.
- `clear` output 1: one-cycle pulse requesting counter/display clear.

## Operation
- Per button: 2-flop synchroniser → `s`; debounce counter `cnt` (32-bit) and debounced level `stable`.
  - `s == stable`: `cnt <= 0`.
  - `s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s`, `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`; the counter restarts from 0 on every bounce.
  - Rising-edge detect on `stable` (registered `stable_d`) gives a one-cycle `press`; the falling edge gives `release`.
- Mode path: `press` on mode → `hex <= ~hex`. Release has no effect.
- Run FSM (states IDLE, HOLD, LONG):
  - IDLE: on run `press` → HOLD, `hold_cnt <= 0`.
  - HOLD: `release` → IDLE, `run <= ~run`. Else if `hold_cnt == LONG_CYCLES-2` → LONG, `clear <= 1` for one cycle, `run` unchanged. Else `hold_cnt++`.
  - LONG: wait for `release` → IDLE; no further pulses while held.
- Both buttons are fully independent. Simultaneous presses are processed in the same cycle.

## Timing
- Reset values (asserted `rst`=0, async): `hex`=0, `run`=`RUN_INIT`, `clear`=0, FSM=IDLE, all sync flops/`stable`/`stable_d`/counters 0.
- Edge numbering: edge 0 is the first edge that samples a new raw level.
  - Sync output valid after edge 1.
  - `stable` changes at edge `DEBOUNCE_CYCLES+1`.
  - `press`/`release` high in the cycle after that edge.
  - `hex`/`run`/FSM update at edge `DEBOUNCE_CYCLES+2`.
- `clear` asserts exactly `LONG_CYCLES` cycles after `press` (counting the cycle `press` is high as cycle 1) and stays high for exactly one cycle.
- A release landing in the same cycle as the long threshold: release wins. The FSM goes to IDLE, `run` toggles and no `clear` is issued.
- Reset mid-press: all state clears. A button still held when `rst` deasserts is debounced afresh and counts as a new press.
- Counters never wrap, because each is bounded by its compare value. Parameter values are used unmodified in 32-bit compares.

## Structure
- Package `count_ctrl_pkg`:
  - FSM enum `run_state_t` {IDLE, HOLD, LONG}, 2-bit.
  - `CNT_W` = 32.
- Sub-module `btn_debounce`: synchroniser, debounce counter, `stable`, `press`/`release`. Parameter `DEBOUNCE_CYCLES`. Instantiated twice.
- Top holds the `hex` toggle flop, the run FSM, `hold_cnt`, and the `clear` register. All outputs are registered.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `RUN_INIT`=1.
- Reset: hold `rst`=0 mid-stream → `hex`=0, `run`=1, `clear`=0 immediately, independent of `clk`.
- Clean mode press: `btn_mode` 0→1 before edge 0, held 10 cycles → `hex` 0→1 at edge 6. Release then press again → `hex` returns to 0. `run` and `clear` unchanged.
- Bounce: `btn_mode` pulses high 3 cycles, low 1, high 3, low → `hex` never toggles. Then held 5 cycles → exactly one toggle.
- Short run press: `btn_run` held 10 cycles then released → `run` 1→0 at release edge + 6. `clear` never asserts.
- Long run press: `btn_run` held 40 cycles → one `clear` pulse 20 cycles after `press`, `run` stays 1, no toggle on release. Release exactly at the threshold cycle → `run` toggles, no `clear`.
- Simultaneous, plus reset while held: both buttons pressed the same cycle → `hex` toggles and the FSM enters HOLD on the same edge. Assert `rst` while `btn_run` is held, deassert → `run`=1, and the held button is processed as a new press.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared types and widths for the count_ctrl button front end.
package count_ctrl_pkg;

   localparam int unsigned CNT_W = 32'd32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LONG = 2'd2
   } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw push-button.
// Emits single-cycle press/release strobes from the debounced level.
module btn_debounce
   import count_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 32'd500000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press,
   output logic o_release
);

   logic             r_meta;
   logic             r_sync;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise, then accept a new level only after it holds for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta     <= 1'b0;
         r_sync     <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= {CNT_W{1'b0}};
      end else begin
         r_meta     <= i_btn;
         r_sync     <= r_meta;
         r_stable_d <= r_stable;
         if (r_sync == r_stable) begin
            r_cnt <= {CNT_W{1'b0}};
         end else if (r_cnt == DEBOUNCE_CYCLES - 32'd1) begin
            r_stable <= r_sync;
            r_cnt    <= {CNT_W{1'b0}};
         end else begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

   assign o_press   = r_stable & ~r_stable_d;
   assign o_release = ~r_stable & r_stable_d;

endmodule

// File: rtl/count_ctrl.sv
// Button front end for the seconds counter: hex/decimal toggle on the mode
// button, and short-press run toggle / long-press clear on the run button.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 32'd500000,
   parameter logic [CNT_W-1:0] LONG_CYCLES     = 32'd50000000,
   parameter logic             RUN_INIT        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_run,
   output logic hex,
   output logic run,
   output logic clear
);

   logic             w_mode_press;
   logic             w_unused_mode_release;
   logic             w_run_press;
   logic             w_run_release;

   logic             r_hex;
   logic             r_run;
   logic             r_clear;
   run_state_t       r_state;
   logic [CNT_W-1:0] r_hold_cnt;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (btn_mode),
      .o_press   (w_mode_press),
      .o_release (w_unused_mode_release)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (btn_run),
      .o_press   (w_run_press),
      .o_release (w_run_release)
   );

   // Display base toggles once per debounced mode press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hex <= 1'b0;
      end else if (w_mode_press) begin
         r_hex <= ~r_hex;
      end else begin
         r_hex <= r_hex;
      end
   end

   // Run button FSM: a release before the long threshold wins over the clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_hold_cnt <= {CNT_W{1'b0}};
         r_run      <= RUN_INIT;
         r_clear    <= 1'b0;
      end else begin
         r_clear <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_run_press) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= {CNT_W{1'b0}};
               end
            end
            HOLD: begin
               if (w_run_release) begin
                  r_state <= IDLE;
                  r_run   <= ~r_run;
               end else if (r_hold_cnt == LONG_CYCLES - 32'd2) begin
                  r_state <= LONG;
                  r_clear <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 32'd1;
               end
            end
            LONG: begin
               if (w_run_release) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign hex   = r_hex;
   assign run   = r_run;
   assign clear = r_clear;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl with a debounce-window / elapsed-cycle model.
module tb_count_ctrl;

   localparam int D = 4;
   localparam int L = 20;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic btn_mode = 1'b0;
   logic btn_run  = 1'b0;
   logic hex;
   logic run;
   logic clear;

   int n_checks  = 0;
   int n_errors  = 0;
   int clear_cnt = 0;

   // model state
   bit hist_mode[$];
   bit hist_run[$];
   bit m_stable_mode, m_stable_run;
   bit m_press_mode, m_press_run, m_rel_run;
   bit exp_hex, exp_run, exp_clear;
   bit holding, long_f;
   int hold_edge, edge_n;

   count_ctrl #(
      .DEBOUNCE_CYCLES (32'd4),
      .LONG_CYCLES     (32'd20),
      .RUN_INIT        (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_run  (btn_run),
      .hex      (hex),
      .run      (run),
      .clear    (clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // A new level is accepted once the synchronised samples seen by the
   // debouncer (raw delayed two edges) have differed from it D times running.
   function automatic bit flips(input bit h[$], input bit cur);
      int n;
      bit v;
      n = h.size() - 1;
      for (int j = n - 1 - D; j <= n - 2; j++) begin
         v = (j >= 0) ? h[j] : 1'b0;
         if (v == cur) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Model advance for the edge just passed, then compare every cycle
   always @(negedge clk) begin
      bit ns;
      if (!rst) begin
         hist_mode.delete();
         hist_run.delete();
         m_stable_mode = 1'b0; m_stable_run = 1'b0;
         m_press_mode = 1'b0; m_press_run = 1'b0; m_rel_run = 1'b0;
         exp_hex = 1'b0; exp_run = 1'b1; exp_clear = 1'b0;
         holding = 1'b0; long_f = 1'b0; hold_edge = 0; edge_n = 0;
      end else begin
         exp_clear = 1'b0;
         if (m_press_mode) exp_hex = !exp_hex;
         if (holding) begin
            if (m_rel_run) begin
               if (!long_f) exp_run = !exp_run;
               holding = 1'b0;
               long_f  = 1'b0;
            end else if (!long_f && (edge_n - hold_edge == L - 1)) begin
               exp_clear = 1'b1;
               long_f    = 1'b1;
            end
         end else if (m_press_run) begin
            holding   = 1'b1;
            hold_edge = edge_n;
         end
         hist_mode.push_back(btn_mode);
         hist_run.push_back(btn_run);
         ns = flips(hist_mode, m_stable_mode) ? !m_stable_mode : m_stable_mode;
         m_press_mode  = ns & !m_stable_mode;
         m_stable_mode = ns;
         ns = flips(hist_run, m_stable_run) ? !m_stable_run : m_stable_run;
         m_press_run  = ns & !m_stable_run;
         m_rel_run    = !ns & m_stable_run;
         m_stable_run = ns;
         edge_n++;
      end
      chk("hex", hex, exp_hex);
      chk("run", run, exp_run);
      chk("clear", clear, exp_clear);
      if (rst && clear) clear_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      step(3);
      chk("reset_hex", hex, 1'b0);
      chk("reset_run", run, 1'b1);
      rst = 1'b1;
      step(3);

      // clean mode press: hex flips at edge 6
      btn_mode = 1'b1;
      step(6); chk("mode_edge5_hex", hex, 1'b0);
      step(1); chk("mode_edge6_hex", hex, 1'b1);
      step(3); btn_mode = 1'b0;
      step(10);
      btn_mode = 1'b1;
      step(7); chk("mode_second_hex", hex, 1'b0);
      step(3); btn_mode = 1'b0;
      step(10);
      chk("mode_run_kept", run, 1'b1);

      // bounce: 3 high, 1 low, 3 high never reaches 4 stable samples
      btn_mode = 1'b1; step(3);
      btn_mode = 1'b0; step(1);
      btn_mode = 1'b1; step(3);
      btn_mode = 1'b0; step(10);
      chk("bounce_hex", hex, 1'b0);
      btn_mode = 1'b1; step(5);
      btn_mode = 1'b0; step(12);
      chk("bounce_then_hold_hex", hex, 1'b1);

      // short run press
      btn_run = 1'b1; step(10);
      btn_run = 1'b0;
      step(6); chk("short_edge5_run", run, 1'b1);
      step(1); chk("short_edge6_run", run, 1'b0);
      step(5);
      chk_int("short_clear_count", clear_cnt, 0);

      // asynchronous reset mid-stream, away from clock edges
      @(posedge clk); #3; rst = 1'b0; #1;
      chk("async_rst_hex", hex, 1'b0);
      chk("async_rst_run", run, 1'b1);
      chk("async_rst_clear", clear, 1'b0);
      @(negedge clk); #2; rst = 1'b1;
      step(3);

      // long run press: clear after edge 25, run kept
      btn_run = 1'b1;
      step(25); chk("long_pre_clear", clear, 1'b0);
      step(1);  chk("long_clear", clear, 1'b1);
      step(1);  chk("long_post_clear", clear, 1'b0);
      step(13); btn_run = 1'b0;
      step(10);
      chk("long_run_kept", run, 1'b1);
      chk_int("long_clear_count", clear_cnt, 1);

      // release on the threshold cycle wins
      btn_run = 1'b1; step(19);
      btn_run = 1'b0; step(12);
      chk("thresh_run_toggled", run, 1'b0);
      chk_int("thresh_clear_count", clear_cnt, 1);

      // release one cycle late: clear, no toggle
      btn_run = 1'b1; step(20);
      btn_run = 1'b0; step(12);
      chk("late_run_kept", run, 1'b0);
      chk_int("late_clear_count", clear_cnt, 2);

      // simultaneous presses, then reset while held
      btn_mode = 1'b1; btn_run = 1'b1;
      step(7); chk("sim_hex", hex, 1'b1);
      step(5);
      @(posedge clk); #3; rst = 1'b0; #1;
      chk("held_rst_run", run, 1'b1);
      chk("held_rst_hex", hex, 1'b0);
      @(negedge clk); #2; rst = 1'b1;
      step(7); chk("held_repress_hex", hex, 1'b1);
      step(3);
      btn_mode = 1'b0; btn_run = 1'b0;
      step(7); chk("held_repress_run", run, 1'b0);
      step(5);
      chk_int("final_clear_count", clear_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
